matrix_loader: RTL and testbench
================================

MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter N_SIZE, default 3, matrix dimension; legal range 1..16.
REQ-002 Parameter DATA_W, default 16, element width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 s_valid  input  1  upstream element valid.
REQ-006 s_ready  output  1  loader accepts element this cycle.
REQ-007 s_data  input  DATA_W  element; stream order is A row-major (N*N words), then B row-major (N*N words).
REQ-008 valid_out  output  1  drives systolic array valid_in.
REQ-009 matrix_a_out  output  N_SIZE x DATA_W  column k of A, one element per array row.
REQ-010 matrix_b_out  output  N_SIZE x DATA_W  row k of B, one element per array column.
REQ-011 result_done  input  1  single-cycle pulse from result collector: current product fully drained.
REQ-012 busy  output  1  high in any state other than LOAD_A with zero elements held.

Function
REQ-013 FSM states: LOAD_A, LOAD_B, ISSUE, WAIT_DONE; encoding from shared package.
REQ-014 Transfer occurs only on a rising edge with s_valid and s_ready both high; s_data is ignored otherwise.
REQ-015 s_ready is high in LOAD_A and LOAD_B and low in ISSUE and WAIT_DONE; it is a registered-state decode with no combinational path from s_valid.
REQ-016 Element counter width is $clog2(N_SIZE*N_SIZE) bits, minimum 1; it wraps to 0 after N*N-1 and selects buffer row = cnt / N, column = cnt % N.
REQ-017 LOAD_A -> LOAD_B on the transfer of A element N*N-1; LOAD_B -> ISSUE on the transfer of B element N*N-1.
REQ-018 valid_out rises on the first rising edge after the edge that accepted the last B element and stays high for exactly N_SIZE consecutive cycles.
REQ-019 In issue cycle k (0..N-1): matrix_a_out[i] = A[i][k] and matrix_b_out[j] = B[k][j]; all outputs are registered.
REQ-020 When valid_out is low, matrix_a_out and matrix_b_out are all-zero.
REQ-021 ISSUE -> WAIT_DONE after issue cycle N-1; WAIT_DONE -> LOAD_A on result_done.
REQ-022 result_done outside WAIT_DONE is ignored; it causes no state change and is not stored.
REQ-023 If result_done arrives in the same cycle as the final issue cycle, it is ignored; the loader waits for a later pulse.
REQ-024 N_SIZE=1: a single-cycle issue with a 1x1 operand.
REQ-025 Arithmetic is limited to the index counters; data is passed through unmodified at DATA_W bits.

Reset
REQ-026 While rst is high on a clock edge: state=LOAD_A, counters=0, valid_out=0, matrix outputs=0, s_ready=0, busy=0.
REQ-027 s_ready returns high on the first edge after rst deasserts.
REQ-028 Reset mid-operation (any state) discards all partial A/B data and any in-flight issue; buffer contents need not be cleared.

Structure
REQ-029 Shared package systolic_pkg holds DATA_W=16, ACC_W=32, and the loader_state_t enum; the systolic array and the collector import the same package.
REQ-030 No sub-module; A and B buffers are N_SIZE x N_SIZE register arrays inside matrix_loader.
REQ-031 Outputs connect port-for-port to the systolic array valid_in, matrix_a_in and matrix_b_in.

Verification
REQ-032 N=3, A={{1,2,3},{4,5,6},{7,8,9}}, B=diag(1,2,3), s_valid held high -> issue cycle 0: a_out={1,4,7}, b_out={1,0,0}; cycle 2: a_out={3,6,9}, b_out={0,0,3}; valid_out high exactly 3 cycles.
REQ-033 Same matrices with s_valid toggled every other cycle -> identical issue sequence; s_data on non-transfer cycles never appears in any output.
REQ-034 rst pulsed after 4 A words accepted, then full clean stream -> outputs match REQ-032 with no trace of the aborted words.
REQ-035 result_done pulsed in LOAD_B and in the last ISSUE cycle -> no state change; s_ready stays low until a later pulse in WAIT_DONE, then rises the next cycle.
REQ-036 N=5 end-to-end with systolic_array, A rows {1..5},{6..10},{11..15},{1..5},{6..10} and B rows {2,4,6,8,10},{12,..,20},{22,..,30},{1..5},{6..10} -> C[0][0]=126, C[0][1]=147, full C equal to software product.
REQ-037 Two back-to-back products with result_done returned each time -> second issue begins no earlier than 2*N*N cycles after result_done; no overlap of valid_out bursts.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix datapath: element and
// accumulator widths, the loader FSM state type and a small sizing helper.
package systolic_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;

  typedef enum logic [1:0] {
    LOAD_A    = 2'd0,
    LOAD_B    = 2'd1,
    ISSUE     = 2'd2,
    WAIT_DONE = 2'd3
  } loader_state_t;

  // Index width for a counter covering 0..n-1, never narrower than one bit.
  function automatic int min1_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// Element stream into the matrix loader: valid/ready handshake plus data.
interface matrix_loader_if #(
  parameter int DATA_W = 16
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/matrix_loader.sv
// Matrix loader: buffers A then B (row-major) from the element stream, then
// issues N_SIZE registered beats of (column k of A, row k of B) to the
// systolic array and waits for the collector to report the product drained.
module matrix_loader #(
  parameter int N_SIZE = 3,
  parameter int DATA_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  matrix_loader_if.slave                s_if,
  output logic                          valid_out,
  output logic [N_SIZE-1:0][DATA_W-1:0] matrix_a_out,
  output logic [N_SIZE-1:0][DATA_W-1:0] matrix_b_out,
  input  logic                          result_done,
  output logic                          busy
);

  import systolic_pkg::*;

  localparam int CNT_W = min1_clog2(N_SIZE * N_SIZE);
  localparam int IDX_W = min1_clog2(N_SIZE);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SIZE * N_SIZE - 1);
  localparam logic [CNT_W-1:0] CNT_N    = CNT_W'(N_SIZE);
  localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(N_SIZE - 1);

  loader_state_t state, state_d;

  logic [CNT_W-1:0] cnt, cnt_d;
  logic [IDX_W-1:0] k, k_d;
  logic             s_ready_q;
  logic             xfer;
  logic             a_we, b_we, issue;
  logic [IDX_W-1:0] row, col;

  logic [DATA_W-1:0] a_buf [N_SIZE][N_SIZE];
  logic [DATA_W-1:0] b_buf [N_SIZE][N_SIZE];

  assign s_if.s_ready = s_ready_q;
  assign xfer         = s_if.s_valid && s_ready_q;
  assign row          = IDX_W'(cnt / CNT_N);
  assign col          = IDX_W'(cnt % CNT_N);
  assign busy         = !((state == LOAD_A) && (cnt == '0));

  // State, counters and the registered ready decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD_A;
      cnt       <= '0;
      k         <= '0;
      s_ready_q <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      k         <= k_d;
      // Ready follows the next state so it drops on the edge that accepts
      // the final B element and rises on the edge that leaves WAIT_DONE.
      s_ready_q <= (state_d == LOAD_A) || (state_d == LOAD_B);
    end
  end

  // Next-state logic, counter advance and buffer/issue strobes.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    k_d     = k;
    a_we    = 1'b0;
    b_we    = 1'b0;
    issue   = 1'b0;
    case (state)
      LOAD_A: begin
        if (xfer) begin
          a_we = 1'b1;
          if (cnt == CNT_LAST) begin
            cnt_d   = '0;
            state_d = LOAD_B;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      LOAD_B: begin
        if (xfer) begin
          b_we = 1'b1;
          if (cnt == CNT_LAST) begin
            cnt_d   = '0;
            k_d     = '0;
            state_d = ISSUE;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      ISSUE: begin
        issue = 1'b1;
        if (k == K_LAST) begin
          k_d     = '0;
          state_d = WAIT_DONE;
        end else begin
          k_d = k + IDX_W'(1);
        end
      end
      WAIT_DONE: begin
        // The last issue beat is still on the outputs during the first
        // WAIT_DONE cycle; a pulse coinciding with it is not a drain report.
        if (result_done && !valid_out) begin
          state_d = LOAD_A;
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  // Operand buffers; contents survive reset and are simply overwritten.
  always_ff @(posedge clk) begin
    if (a_we) begin
      a_buf[row][col] <= s_if.s_data;
    end
    if (b_we) begin
      b_buf[row][col] <= s_if.s_data;
    end
  end

  // Registered issue beat: column k of A and row k of B, zero when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out    <= 1'b0;
      matrix_a_out <= '0;
      matrix_b_out <= '0;
    end else if (issue) begin
      valid_out <= 1'b1;
      for (int unsigned i = 0; i < N_SIZE; i++) begin
        matrix_a_out[i] <= a_buf[i][k];
        matrix_b_out[i] <= b_buf[k][i];
      end
    end else begin
      valid_out    <= 1'b0;
      matrix_a_out <= '0;
      matrix_b_out <= '0;
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Bench for matrix_loader: N=3 main instance, N=5 end-to-end product check
// and an N=1 corner instance, all driven from one initial block.
module tb_matrix_loader;

  localparam int N  = 3;
  localparam int N5 = 5;
  localparam int DW = 16;

  typedef logic [DW-1:0] mat_t [16][16];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned cycle_no = 0;
  int unsigned rise_cycle = 0;

  always @(posedge clk) cycle_no <= cycle_no + 1;

  // N=3 instance
  matrix_loader_if #(.DATA_W(DW)) sif3 ();
  logic rd3, vo3, busy3;
  logic [N-1:0][DW-1:0] ao3, bo3;
  matrix_loader #(.N_SIZE(N), .DATA_W(DW)) u3 (
    .clk(clk), .rst(rst), .s_if(sif3), .valid_out(vo3),
    .matrix_a_out(ao3), .matrix_b_out(bo3), .result_done(rd3), .busy(busy3)
  );

  // N=5 instance
  matrix_loader_if #(.DATA_W(DW)) sif5 ();
  logic rd5, vo5, busy5;
  logic [N5-1:0][DW-1:0] ao5, bo5;
  matrix_loader #(.N_SIZE(N5), .DATA_W(DW)) u5 (
    .clk(clk), .rst(rst), .s_if(sif5), .valid_out(vo5),
    .matrix_a_out(ao5), .matrix_b_out(bo5), .result_done(rd5), .busy(busy5)
  );

  // N=1 instance
  matrix_loader_if #(.DATA_W(DW)) sif1 ();
  logic rd1, vo1, busy1;
  logic [0:0][DW-1:0] ao1, bo1;
  matrix_loader #(.N_SIZE(1), .DATA_W(DW)) u1 (
    .clk(clk), .rst(rst), .s_if(sif1), .valid_out(vo1),
    .matrix_a_out(ao1), .matrix_b_out(bo1), .result_done(rd1), .busy(busy1)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic mat_t rnd_mat();
    mat_t m;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        m[i][j] = 16'($urandom_range(0, 16'h0FFF));
    return m;
  endfunction

  // Non-transfer filler lives in 0xF000..0xFFFF, never a legal operand value.
  function automatic logic [DW-1:0] junk();
    return 16'hF000 | 16'($urandom_range(0, 16'h0FFF));
  endfunction

  // mode 0: valid always, 1: toggled, 2: random. Pulses rd3 once when
  // transfer index done_at is being offered.
  task automatic stream3(input mat_t a, input mat_t b, input int mode,
                         input int words, input int done_at);
    int idx = 0;
    int cyc = 0;
    bit ph = 1'b1;
    bit pulsed = 1'b0;
    logic v;
    logic [DW-1:0] w;
    while (idx < words && cyc < 400) begin
      @(negedge clk);
      if (idx == done_at && !pulsed) begin
        rd3 = 1'b1;
        pulsed = 1'b1;
      end else begin
        rd3 = 1'b0;
      end
      case (mode)
        0: v = 1'b1;
        1: v = ph;
        default: v = 1'($urandom_range(0, 1));
      endcase
      ph = ~ph;
      w = (idx < N*N) ? a[idx/N][idx%N] : b[(idx-N*N)/N][(idx-N*N)%N];
      sif3.s_valid = v;
      sif3.s_data  = v ? w : junk();
      if (v && sif3.s_ready) idx++;
      cyc++;
    end
    vectors++;
    if (idx < words) begin
      errors++;
      $display("FAIL stream3_timeout: accepted %0d words, required %0d", idx, words);
    end
    @(negedge clk);
    sif3.s_valid = 1'b0;
    sif3.s_data  = junk();
    rd3 = 1'b0;
  endtask

  // Called at the negedge after the final B word was accepted.
  task automatic capture3(input mat_t a, input mat_t b, input bit done_last,
                          input string tag);
    int cyc = 0;
    logic [N-1:0][DW-1:0] ea, eb;
    while (vo3 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    rise_cycle = cycle_no;
    vectors++;
    if (cyc != 1) begin
      errors++;
      $display("FAIL %s_latency: valid_out rose after %0d cycles, required 1", tag, cyc);
    end
    for (int k = 0; k < N; k++) begin
      if (k > 0) @(negedge clk);
      if (k == N-1 && done_last) rd3 = 1'b1;
      for (int i = 0; i < N; i++) begin
        ea[i] = a[i][k];
        eb[i] = b[k][i];
      end
      vectors++;
      if (vo3 !== 1'b1 || sif3.s_ready !== 1'b0 || busy3 !== 1'b1) begin
        errors++;
        $display("FAIL %s_issue%0d_ctl: valid=%b ready=%b busy=%b, required 1 0 1",
                 tag, k, vo3, sif3.s_ready, busy3);
      end
      vectors++;
      if (ao3 !== ea) begin
        errors++;
        $display("FAIL %s_a_out%0d: got %h, required %h", tag, k, ao3, ea);
      end
      vectors++;
      if (bo3 !== eb) begin
        errors++;
        $display("FAIL %s_b_out%0d: got %h, required %h", tag, k, bo3, eb);
      end
    end
    @(negedge clk);
    rd3 = 1'b0;
    vectors++;
    if (vo3 !== 1'b0 || ao3 !== '0 || bo3 !== '0) begin
      errors++;
      $display("FAIL %s_post_burst: valid=%b a=%h b=%h, required 0 and zero data",
               tag, vo3, ao3, bo3);
    end
  endtask

  // Called while waiting for the drain report.
  task automatic finish3(input string tag);
    vectors++;
    if (sif3.s_ready !== 1'b0 || busy3 !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait: ready=%b busy=%b, required 0 1", tag, sif3.s_ready, busy3);
    end
    rd3 = 1'b1;
    @(negedge clk);
    rd3 = 1'b0;
    vectors++;
    if (sif3.s_ready !== 1'b1 || busy3 !== 1'b0) begin
      errors++;
      $display("FAIL %s_release: ready=%b busy=%b, required 1 0", tag, sif3.s_ready, busy3);
    end
  endtask

  function automatic void directed_mats(output mat_t a, output mat_t b);
    a = rnd_mat();
    b = rnd_mat();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a[i][j] = 16'(i*N + j + 1);
        b[i][j] = (i == j) ? 16'(i + 1) : 16'd0;
      end
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    sif3.s_valid = 1'b1;
    sif3.s_data  = junk();
    repeat (3) @(negedge clk);
    vectors++;
    if (vo3 !== 1'b0 || ao3 !== '0 || bo3 !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b a=%h b=%h, required all zero", vo3, ao3, bo3);
    end
    vectors++;
    if (sif3.s_ready !== 1'b0 || busy3 !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: ready=%b busy=%b, required 0 0", sif3.s_ready, busy3);
    end
    rst = 1'b0;
    sif3.s_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (sif3.s_ready !== 1'b1 || busy3 !== 1'b0 || sif5.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: ready3=%b busy3=%b ready5=%b, required 1 0 1",
               sif3.s_ready, busy3, sif5.s_ready);
    end
  endtask

  task automatic test_directed();
    mat_t a, b;
    directed_mats(a, b);
    stream3(a, b, 0, 2*N*N, -1);
    capture3(a, b, 1'b0, "directed");
    finish3("directed");
  endtask

  task automatic test_toggle();
    mat_t a, b;
    directed_mats(a, b);
    stream3(a, b, 1, 2*N*N, -1);
    capture3(a, b, 1'b0, "toggle_dir");
    finish3("toggle_dir");
    a = rnd_mat();
    b = rnd_mat();
    stream3(a, b, 1, 2*N*N, -1);
    capture3(a, b, 1'b0, "toggle_rnd");
    finish3("toggle_rnd");
  endtask

  task automatic test_random();
    mat_t a, b;
    for (int r = 0; r < 4; r++) begin
      a = rnd_mat();
      b = rnd_mat();
      stream3(a, b, 2, 2*N*N, -1);
      capture3(a, b, 1'b0, "random");
      finish3("random");
    end
  endtask

  task automatic test_done_ignored();
    mat_t a, b;
    a = rnd_mat();
    b = rnd_mat();
    stream3(a, b, 0, 2*N*N, N*N + 2);
    capture3(a, b, 1'b1, "done_ign");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (sif3.s_ready !== 1'b0 || vo3 !== 1'b0) begin
        errors++;
        $display("FAIL done_ign_hold%0d: ready=%b valid=%b, required 0 0",
                 c, sif3.s_ready, vo3);
      end
    end
    finish3("done_ign");
  endtask

  task automatic test_reset_mid();
    mat_t a, b, ja, jb;
    ja = rnd_mat();
    jb = rnd_mat();
    stream3(ja, jb, 0, 4, -1);
    vectors++;
    if (busy3 !== 1'b1) begin
      errors++;
      $display("FAIL midload_busy: busy=%b, required 1", busy3);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    directed_mats(a, b);
    stream3(a, b, 0, 2*N*N, -1);
    capture3(a, b, 1'b0, "after_rst_load");
    finish3("after_rst_load");
    // Reset while the burst is on the outputs.
    stream3(ja, jb, 0, 2*N*N, -1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (vo3 !== 1'b0 || ao3 !== '0 || sif3.s_ready !== 1'b0) begin
      errors++;
      $display("FAIL issue_rst: valid=%b a=%h ready=%b, required 0 zero 0",
               vo3, ao3, sif3.s_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (vo3 !== 1'b0 || sif3.s_ready !== 1'b1 || busy3 !== 1'b0) begin
      errors++;
      $display("FAIL issue_rst_release: valid=%b ready=%b busy=%b, required 0 1 0",
               vo3, sif3.s_ready, busy3);
    end
    a = rnd_mat();
    b = rnd_mat();
    stream3(a, b, 0, 2*N*N, -1);
    capture3(a, b, 1'b0, "after_rst_issue");
    finish3("after_rst_issue");
  endtask

  task automatic test_back_to_back();
    mat_t a, b;
    int unsigned t_done;
    a = rnd_mat();
    b = rnd_mat();
    stream3(a, b, 0, 2*N*N, -1);
    capture3(a, b, 1'b0, "b2b_first");
    t_done = cycle_no;
    finish3("b2b_first");
    a = rnd_mat();
    b = rnd_mat();
    stream3(a, b, 0, 2*N*N, -1);
    capture3(a, b, 1'b0, "b2b_second");
    vectors++;
    if (rise_cycle - t_done < 2*N*N) begin
      errors++;
      $display("FAIL b2b_gap: %0d cycles between done and issue, required >= %0d",
               rise_cycle - t_done, 2*N*N);
    end
    finish3("b2b_second");
  endtask

  task automatic test_n5_product();
    mat_t a, b;
    logic [31:0] c [N5][N5];
    logic [31:0] ref_c;
    int idx = 0;
    int cyc = 0;
    int beats = 0;
    logic [DW-1:0] w;
    for (int i = 0; i < N5; i++) begin
      for (int j = 0; j < N5; j++) begin
        a[i][j] = 16'(((i % 3) * 5) + j + 1);
        c[i][j] = '0;
      end
    end
    for (int j = 0; j < N5; j++) begin
      b[0][j] = 16'(2 + 2*j);
      b[1][j] = 16'(12 + 2*j);
      b[2][j] = 16'(22 + 2*j);
      b[3][j] = 16'(1 + j);
      b[4][j] = 16'(6 + j);
    end
    while (idx < 2*N5*N5 && cyc < 400) begin
      @(negedge clk);
      w = (idx < N5*N5) ? a[idx/N5][idx%N5] : b[(idx-N5*N5)/N5][(idx-N5*N5)%N5];
      sif5.s_valid = 1'b1;
      sif5.s_data  = w;
      if (sif5.s_ready) idx++;
      cyc++;
    end
    @(negedge clk);
    sif5.s_valid = 1'b0;
    sif5.s_data  = junk();
    cyc = 0;
    while (cyc < 30) begin
      if (vo5 === 1'b1) begin
        beats++;
        for (int i = 0; i < N5; i++)
          for (int j = 0; j < N5; j++)
            c[i][j] = c[i][j] + 32'(ao5[i]) * 32'(bo5[j]);
      end
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (beats != N5) begin
      errors++;
      $display("FAIL n5_beats: valid_out high %0d cycles, required %0d", beats, N5);
    end
    vectors++;
    if (c[0][0] !== 32'd126 || c[0][1] !== 32'd147) begin
      errors++;
      $display("FAIL n5_c00_c01: got %0d %0d, required 126 147", c[0][0], c[0][1]);
    end
    for (int i = 0; i < N5; i++) begin
      for (int j = 0; j < N5; j++) begin
        ref_c = '0;
        for (int k = 0; k < N5; k++) ref_c = ref_c + 32'(a[i][k]) * 32'(b[k][j]);
        vectors++;
        if (c[i][j] !== ref_c) begin
          errors++;
          $display("FAIL n5_c%0d%0d: got %0d, required %0d", i, j, c[i][j], ref_c);
        end
      end
    end
    rd5 = 1'b1;
    @(negedge clk);
    rd5 = 1'b0;
    vectors++;
    if (sif5.s_ready !== 1'b1) begin
      errors++;
      $display("FAIL n5_release: ready=%b, required 1", sif5.s_ready);
    end
  endtask

  task automatic test_n1();
    logic [DW-1:0] x, y, w;
    int idx = 0;
    int cyc = 0;
    x = 16'($urandom_range(0, 16'h0FFF));
    y = 16'($urandom_range(0, 16'h0FFF));
    while (idx < 2 && cyc < 20) begin
      @(negedge clk);
      w = (idx == 0) ? x : y;
      sif1.s_valid = 1'b1;
      sif1.s_data  = w;
      if (sif1.s_ready) idx++;
      cyc++;
    end
    @(negedge clk);
    sif1.s_valid = 1'b0;
    sif1.s_data  = junk();
    @(negedge clk);
    vectors++;
    if (vo1 !== 1'b1 || ao1 !== x || bo1 !== y) begin
      errors++;
      $display("FAIL n1_issue: valid=%b a=%h b=%h, required 1 %h %h", vo1, ao1, bo1, x, y);
    end
    @(negedge clk);
    vectors++;
    if (vo1 !== 1'b0 || ao1 !== '0 || sif1.s_ready !== 1'b0 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL n1_post: valid=%b a=%h ready=%b busy=%b, required 0 0 0 1",
               vo1, ao1, sif1.s_ready, busy1);
    end
    rd1 = 1'b1;
    @(negedge clk);
    rd1 = 1'b0;
    vectors++;
    if (sif1.s_ready !== 1'b1 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL n1_release: ready=%b busy=%b, required 1 0", sif1.s_ready, busy1);
    end
  endtask

  initial begin
    rst = 1'b1;
    rd3 = 1'b0;
    rd5 = 1'b0;
    rd1 = 1'b0;
    sif3.s_valid = 1'b0;
    sif3.s_data  = '0;
    sif5.s_valid = 1'b0;
    sif5.s_data  = '0;
    sif1.s_valid = 1'b0;
    sif1.s_data  = '0;
    test_reset();
    test_directed();
    test_toggle();
    test_random();
    test_done_ignored();
    test_reset_mid();
    test_back_to_back();
    test_n5_product();
    test_n1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
